// File: rtl/ts_sync_align_pkg.sv
// Shared transport-stream constants and sync-FSM state encoding.
// Also used by the de-interleaver and RS decoder.
package ts_sync_align_pkg;

    localparam int          TS_PKT_LEN    = 204;
    localparam logic [7:0]  TS_SYNC_BYTE  = 8'h47;
    localparam logic [7:0]  TS_SYNC_INV   = 8'hB8;
    localparam int          TS_LOCK_CNT   = 3;
    localparam int          TS_UNLOCK_CNT = 3;

    // 2'd3 is unused and recovers to ST_SEARCH
    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCK   = 2'd2
    } ts_state_t;

endpackage

// File: rtl/ts_sync_align.sv
// Byte-level TS sync acquisition: locks to the 0x47/0xB8 byte recurring every
// PKT_LEN bytes, forwards all bytes with a one-cycle delay and flags packet starts.
module ts_sync_align
    import ts_sync_align_pkg::*;
#(
    parameter int         PKT_LEN    = TS_PKT_LEN,
    parameter logic [7:0] SYNC_BYTE  = TS_SYNC_BYTE,
    parameter logic [7:0] SYNC_INV   = TS_SYNC_INV,
    parameter int         LOCK_CNT   = TS_LOCK_CNT,
    parameter int         UNLOCK_CNT = TS_UNLOCK_CNT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] din_byte,
    input  logic       din_valid,
    output logic [7:0] dout_byte,
    output logic       dout_valid,
    output logic       syn_out,
    output logic       sframe_out,
    output logic       lock
);

    localparam logic [7:0] POS_LAST  = 8'(PKT_LEN - 1);
    localparam logic [2:0] LOCK_N    = 3'(LOCK_CNT);
    localparam logic [2:0] UNLOCK_N  = 3'(UNLOCK_CNT);

    ts_state_t  r_state;
    logic [7:0] r_pos;
    logic [2:0] r_hits;
    logic [2:0] r_miss;
    logic [7:0] r_dout_byte;
    logic       r_dout_valid;
    logic       r_syn;
    logic       r_sframe;
    logic       r_lock;

    logic       w_is_inv;
    logic       w_is_sync;
    logic       w_pos0;
    logic [7:0] w_pos_inc;

    assign w_is_inv  = (din_byte == SYNC_INV);
    assign w_is_sync = (din_byte == SYNC_BYTE) || w_is_inv;
    assign w_pos0    = (r_pos == 8'd0);
    assign w_pos_inc = (r_pos == POS_LAST) ? 8'd0 : r_pos + 8'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_SEARCH;
            r_pos        <= 8'd0;
            r_hits       <= 3'd0;
            r_miss       <= 3'd0;
            r_dout_byte  <= 8'd0;
            r_dout_valid <= 1'b0;
            r_syn        <= 1'b0;
            r_sframe     <= 1'b0;
            r_lock       <= 1'b0;
        end else begin
            r_dout_valid <= din_valid;
            r_syn        <= 1'b0;
            r_sframe     <= 1'b0;
            if (din_valid) begin
                r_dout_byte <= din_byte;
                case (r_state)
                    ST_SEARCH: begin
                        if (w_is_sync) begin
                            r_pos  <= 8'd1;
                            r_hits <= 3'd1;
                            if (LOCK_N == 3'd1) begin
                                r_state  <= ST_LOCK;
                                r_miss   <= 3'd0;
                                r_lock   <= 1'b1;
                                r_syn    <= 1'b1;
                                r_sframe <= w_is_inv;
                            end else begin
                                r_state <= ST_VERIFY;
                            end
                        end
                    end
                    ST_VERIFY: begin
                        r_pos <= w_pos_inc;
                        if (w_pos0) begin
                            if (w_is_sync) begin
                                r_hits <= r_hits + 3'd1;
                                if (r_hits + 3'd1 == LOCK_N) begin
                                    r_state  <= ST_LOCK;
                                    r_miss   <= 3'd0;
                                    r_lock   <= 1'b1;
                                    r_syn    <= 1'b1;
                                    r_sframe <= w_is_inv;
                                end
                            end else begin
                                // the failing byte is not reconsidered as a new candidate
                                r_state <= ST_SEARCH;
                                r_hits  <= 3'd0;
                                r_pos   <= 8'd0;
                            end
                        end
                    end
                    ST_LOCK: begin
                        r_pos <= w_pos_inc;
                        if (w_pos0) begin
                            if (w_is_sync) begin
                                r_miss   <= 3'd0;
                                r_syn    <= 1'b1;
                                r_sframe <= w_is_inv;
                            end else if (r_miss + 3'd1 == UNLOCK_N) begin
                                r_state <= ST_SEARCH;
                                r_pos   <= 8'd0;
                                r_hits  <= 3'd0;
                                r_miss  <= 3'd0;
                                r_lock  <= 1'b0;
                            end else begin
                                // flywheel: keep marking packet starts through short fades
                                r_miss <= r_miss + 3'd1;
                                r_syn  <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        r_state <= ST_SEARCH;
                        r_pos   <= 8'd0;
                        r_hits  <= 3'd0;
                        r_miss  <= 3'd0;
                        r_lock  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign dout_byte  = r_dout_byte;
    assign dout_valid = r_dout_valid;
    assign syn_out    = r_syn;
    assign sframe_out = r_sframe;
    assign lock       = r_lock;

endmodule
